// File: rtl/ram_responder.sv
// Behavioural RAM end of the cpu_ram interface: fixed-latency BUSY/ACCESS
// handshake on memREN/memWEN, plus a preload port for bench initialisation.
module ram_responder #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned LAT         = 2
) (
    input  logic                           CLK,
    input  logic                           RST,
    input  logic [31:0]                    memaddr,
    input  logic [31:0]                    memstore,
    input  logic                           memREN,
    input  logic                           memWEN,
    output logic [31:0]                    ramload,
    output logic [1:0]                     ramstate,
    input  logic                           load_en,
    input  logic [$clog2(DEPTH_WORDS)-1:0] load_addr,
    input  logic [31:0]                    load_data
);

    localparam int unsigned AW    = $clog2(DEPTH_WORDS);
    localparam logic [3:0]  LAT_C = 4'(LAT);

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ram_state_e;

    logic [31:0]   mem_q [DEPTH_WORDS];
    logic [3:0]    cnt_q, cnt_d;
    logic [AW-1:0] last_addr_q, last_addr_d;
    logic          last_ren_q, last_ren_d;
    logic          last_wen_q, last_wen_d;

    ram_state_e    state;
    logic [29:0]   req_idx;
    logic [AW-1:0] idx;
    logic          in_range;
    logic          same_req;
    logic [3:0]    eff_cnt;
    logic          wr_en;
    logic          unused_byte_bits;

    assign unused_byte_bits = ^memaddr[1:0];

    always_comb begin
        req_idx     = memaddr[31:2];
        idx         = req_idx[AW-1:0];
        in_range    = ({2'b00, req_idx} < 32'(DEPTH_WORDS));
        same_req    = (last_ren_q == memREN) && (last_wen_q == memWEN) &&
                      (last_addr_q == idx);
        eff_cnt     = '0;
        state       = FREE;
        cnt_d       = '0;
        last_addr_d = '0;
        last_ren_d  = 1'b0;
        last_wen_d  = 1'b0;
        wr_en       = 1'b0;

        if (!memREN && !memWEN) begin
            state = FREE;
        end else if ((memREN && memWEN) || !in_range) begin
            state = ERROR;
        end else begin
            // A request that differs from the captured tag starts counting from zero
            eff_cnt     = same_req ? cnt_q : '0;
            last_addr_d = idx;
            last_ren_d  = memREN;
            last_wen_d  = memWEN;
            if (eff_cnt == LAT_C) begin
                state = ACCESS;
                wr_en = memWEN;
            end else begin
                state = BUSY;
                cnt_d = eff_cnt + 4'd1;
            end
        end
    end

    always_comb begin
        ramstate = RST ? FREE : state;
        ramload  = '0;
        if (!RST && state == ACCESS && memREN) begin
            ramload = mem_q[idx];
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cnt_q       <= '0;
            last_addr_q <= '0;
            last_ren_q  <= 1'b0;
            last_wen_q  <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            last_addr_q <= last_addr_d;
            last_ren_q  <= last_ren_d;
            last_wen_q  <= last_wen_d;
        end
    end

    // Bus write is issued after preload so it wins on a same-word collision
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int unsigned i = 0; i < DEPTH_WORDS; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (load_en) begin
                mem_q[load_addr] <= load_data;
            end
            if (wr_en) begin
                mem_q[idx] <= memstore;
            end
        end
    end

endmodule

// File: tb/tb_ram_responder.sv
// Scoreboard bench: three ram_responder instances (LAT 2, 0, 3) share stimulus
// and are compared every cycle against a transaction-level reference model.
module tb_ram_responder;

    localparam int unsigned DEPTH = 1024;

    logic        clk;
    logic        RST;
    logic [31:0] memaddr;
    logic [31:0] memstore;
    logic        memREN;
    logic        memWEN;
    logic        load_en;
    logic [9:0]  load_addr;
    logic [31:0] load_data;
    logic [31:0] rl [3];
    logic [1:0]  rs [3];

    ram_responder #(.DEPTH_WORDS(DEPTH), .LAT(2)) dut_l2 (
        .CLK(clk), .RST(RST), .memaddr(memaddr), .memstore(memstore),
        .memREN(memREN), .memWEN(memWEN), .ramload(rl[0]), .ramstate(rs[0]),
        .load_en(load_en), .load_addr(load_addr), .load_data(load_data));

    ram_responder #(.DEPTH_WORDS(DEPTH), .LAT(0)) dut_l0 (
        .CLK(clk), .RST(RST), .memaddr(memaddr), .memstore(memstore),
        .memREN(memREN), .memWEN(memWEN), .ramload(rl[1]), .ramstate(rs[1]),
        .load_en(load_en), .load_addr(load_addr), .load_data(load_data));

    ram_responder #(.DEPTH_WORDS(DEPTH), .LAT(3)) dut_l3 (
        .CLK(clk), .RST(RST), .memaddr(memaddr), .memstore(memstore),
        .memREN(memREN), .memWEN(memWEN), .ramload(rl[2]), .ramstate(rs[2]),
        .load_en(load_en), .load_addr(load_addr), .load_data(load_data));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0][1:0]  st;
        logic [2:0][31:0] ld;
    } exp_t;

    exp_t        sb_q[$];
    int unsigned n_cmp  = 0;
    int unsigned n_fail = 0;

    int unsigned lats [3] = '{2, 0, 3};
    logic [31:0] mm   [3][DEPTH];
    int unsigned age  [3];
    logic [31:0] pkey [3];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            for (int i = 0; i < 3; i++) begin
                check($sformatf("ramstate_lat%0d", lats[i]), 32'(rs[i]), 32'(e.st[i]));
                check($sformatf("ramload_lat%0d", lats[i]), rl[i], e.ld[i]);
            end
        end
    end

    task automatic model_clear();
        for (int i = 0; i < 3; i++) begin
            age[i]  = 0;
            pkey[i] = '0;
            for (int w = 0; w < int'(DEPTH); w++) mm[i][w] = '0;
        end
    endtask

    task automatic do_reset();
        exp_t e;
        RST     = 1'b1;
        load_en = 1'b0;
        e       = '0;
        sb_q.push_back(e);
        model_clear();
        @(posedge clk);
        #1;
        RST = 1'b0;
    endtask

    // Expected state: a transaction has been held for age cycles; it reaches
    // ACCESS once age equals the latency, then a held request begins anew.
    task automatic step(input logic ren, input logic wen, input logic [31:0] addr,
                        input logic [31:0] data, input logic le,
                        input logic [9:0] la, input logic [31:0] ldat);
        exp_t        e;
        logic [29:0] idx;
        logic [31:0] key;
        logic        commit;
        memREN    = ren;
        memWEN    = wen;
        memaddr   = addr;
        memstore  = data;
        load_en   = le;
        load_addr = la;
        load_data = ldat;
        idx       = addr[31:2];
        key       = {ren, wen, idx};
        e         = '0;
        for (int i = 0; i < 3; i++) begin
            commit = 1'b0;
            if (!ren && !wen) begin
                e.st[i] = 2'd0;
                age[i]  = 0;
                pkey[i] = '0;
            end else if ((ren && wen) || idx >= 30'(DEPTH)) begin
                e.st[i] = 2'd3;
                age[i]  = 0;
                pkey[i] = '0;
            end else begin
                if (key != pkey[i]) age[i] = 0;
                pkey[i] = key;
                if (age[i] == lats[i]) begin
                    e.st[i] = 2'd2;
                    e.ld[i] = ren ? mm[i][idx[9:0]] : 32'h0;
                    commit  = wen;
                    age[i]  = 0;
                end else begin
                    e.st[i] = 2'd1;
                    age[i]  = age[i] + 1;
                end
            end
            if (le) mm[i][la] = ldat;
            if (commit) mm[i][idx[9:0]] = data;
        end
        sb_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic hold(input logic ren, input logic wen, input logic [31:0] addr,
                        input logic [31:0] data, input int unsigned n);
        for (int unsigned k = 0; k < n; k++) step(ren, wen, addr, data, 1'b0, '0, '0);
    endtask

    initial begin
        logic        r_ren, r_wen;
        logic [31:0] r_addr;
        int unsigned r_hold, sel;

        RST = 1'b1; memaddr = '0; memstore = '0; memREN = 1'b0; memWEN = 1'b0;
        load_en = 1'b0; load_addr = '0; load_data = '0;
        model_clear();
        @(posedge clk);
        #1;
        do_reset();

        step(1'b0, 1'b0, '0, '0, 1'b1, 10'd4, 32'hDEADBEEF);
        hold(1'b1, 1'b0, 32'h10, '0, 4);
        hold(1'b0, 1'b0, '0, '0, 1);

        hold(1'b0, 1'b1, 32'h20, 32'h12345678, 3);
        hold(1'b0, 1'b0, '0, '0, 1);
        hold(1'b1, 1'b0, 32'h20, '0, 4);
        hold(1'b0, 1'b0, '0, '0, 1);

        hold(1'b0, 1'b1, 32'h40, 32'hA5A5A5A5, 1);
        hold(1'b0, 1'b1, 32'h44, 32'h5A5A5A5A, 3);
        hold(1'b0, 1'b0, '0, '0, 1);
        hold(1'b1, 1'b0, 32'h40, '0, 4);

        hold(1'b1, 1'b1, 32'h20, 32'hFFFFFFFF, 2);
        hold(1'b1, 1'b0, 32'h1000, '0, 2);
        hold(1'b0, 1'b0, '0, '0, 1);
        hold(1'b1, 1'b0, 32'h20, '0, 4);

        hold(1'b1, 1'b0, 32'h10, '0, 1);
        hold(1'b1, 1'b0, 32'h11, '0, 1);
        hold(1'b1, 1'b0, 32'h13, '0, 1);
        hold(1'b0, 1'b0, '0, '0, 1);

        hold(1'b1, 1'b0, 32'h10, '0, 1);
        memREN = 1'b1; memaddr = 32'h10;
        do_reset();
        hold(1'b1, 1'b0, 32'h10, '0, 3);
        hold(1'b0, 1'b0, '0, '0, 1);
        step(1'b0, 1'b0, '0, '0, 1'b1, 10'd4, 32'hCAFEF00D);
        hold(1'b1, 1'b0, 32'h10, '0, 8);
        hold(1'b0, 1'b0, '0, '0, 1);

        r_hold = 0; r_ren = 1'b0; r_wen = 1'b0; r_addr = '0;
        for (int n = 0; n < 2500; n++) begin
            if (r_hold == 0) begin
                sel    = $urandom_range(0, 9);
                r_ren  = (sel >= 2 && sel < 5) || sel >= 8;
                r_wen  = (sel >= 5 && sel < 9);
                r_addr = {27'($urandom_range(0, 7)), 5'b0} >> 3;
                if (sel == 9) r_addr = 32'($urandom_range(1024, 4095)) << 2;
                r_hold = $urandom_range(1, 8);
            end
            r_hold--;
            r_addr[1:0] = 2'($urandom);
            if ($urandom_range(0, 299) == 0) begin
                memREN = r_ren; memWEN = r_wen; memaddr = r_addr;
                do_reset();
            end else begin
                step(r_ren, r_wen, r_addr, $urandom, ($urandom_range(0, 5) == 0),
                     10'($urandom_range(0, 3)), $urandom);
            end
        end
        hold(1'b0, 1'b0, '0, '0, 1);

        @(negedge clk);
        #1;
        n_cmp++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d entries expected 0", sb_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
